// File: rtl/wb_retire.sv
// Writeback/retire stage: holds one in-flight instruction, selects its result
// (waiting for and extracting load data when needed) and writes the register file.
module wb_retire #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_uimm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_br_en,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [OFF_W-1:0] in_off,
  input  logic             flush,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [RD_W-1:0]  rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE, DRAIN} state_e;

  typedef enum logic [3:0] {
    SEL_ALU  = 4'd0,
    SEL_BR   = 4'd1,
    SEL_UIMM = 4'd2,
    SEL_LW   = 4'd3,
    SEL_LH   = 4'd4,
    SEL_LHU  = 4'd5,
    SEL_LB   = 4'd6,
    SEL_LBU  = 4'd7,
    SEL_PC4  = 4'd8,
    SEL_LD   = 4'd9,
    SEL_LWU  = 4'd10
  } sel_e;

  state_e           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             rfWe_q, rfWe_d;
  logic [RD_W-1:0]  rfRd_q, rfRd_d;
  logic [XLEN-1:0]  rfWdata_q, rfWdata_d;
  logic [CNT_W-1:0] retireCount_q, retireCount_d;

  logic             accept;
  logic             inIsLoad;
  logic [XLEN-1:0]  directResult;
  logic [XLEN-1:0]  rotWord;
  logic [XLEN-1:0]  loadData;
  logic             doWrite;
  logic [RD_W-1:0]  writeRd;
  logic [XLEN-1:0]  writeData;

  assign in_ready = rst && !flush && (state_q == IDLE || state_q == WRITE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    inIsLoad = 1'b0;
    case (in_sel)
      SEL_LW, SEL_LH, SEL_LHU, SEL_LB, SEL_LBU, SEL_LD, SEL_LWU: inIsLoad = 1'b1;
      default: inIsLoad = 1'b0;
    endcase
  end

  always_comb begin
    directResult = in_alu;
    case (in_sel)
      SEL_BR:   directResult = XLEN'(in_br_en);
      SEL_UIMM: directResult = in_uimm;
      SEL_PC4:  directResult = in_pc + XLEN'(4);
      default:  directResult = in_alu;
    endcase
  end

  // Rotating the doubled word makes misaligned halves/words wrap within the word.
  assign rotWord = XLEN'({mem_rdata, mem_rdata} >> {off_q, 3'b000});

  always_comb begin
    loadData = XLEN'($signed(rotWord[31:0]));
    case (sel_q)
      SEL_LB:  loadData = XLEN'($signed(rotWord[7:0]));
      SEL_LBU: loadData = XLEN'(rotWord[7:0]);
      SEL_LH:  loadData = XLEN'($signed(rotWord[15:0]));
      SEL_LHU: loadData = XLEN'(rotWord[15:0]);
      SEL_LWU: loadData = (XLEN == 32) ? XLEN'($signed(rotWord[31:0])) : XLEN'(rotWord[31:0]);
      SEL_LD:  loadData = (XLEN == 32) ? XLEN'($signed(rotWord[31:0])) : mem_rdata;
      default: loadData = XLEN'($signed(rotWord[31:0]));
    endcase
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    off_d         = off_q;
    rd_d          = rd_q;
    rfWe_d        = 1'b0;
    rfRd_d        = rfRd_q;
    rfWdata_d     = rfWdata_q;
    retireCount_d = retireCount_q;
    doWrite       = 1'b0;
    writeRd       = rd_q;
    writeData     = loadData;

    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept) begin
          sel_d = in_sel;
          off_d = in_off;
          rd_d  = in_rd;
          if (inIsLoad) begin
            state_d = WAIT_MEM;
          end else begin
            state_d   = WRITE;
            doWrite   = 1'b1;
            writeRd   = in_rd;
            writeData = directResult;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_d = mem_resp_valid ? IDLE : DRAIN;
        end else if (mem_resp_valid) begin
          state_d = WRITE;
          doWrite = 1'b1;
        end
      end
      DRAIN: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // rd=0 still retires, but the write port keeps showing the last real write.
    if (doWrite) begin
      retireCount_d = retireCount_q + CNT_W'(1);
      rfWe_d        = |writeRd;
      if (|writeRd) begin
        rfRd_d    = writeRd;
        rfWdata_d = writeData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      rfWe_q        <= 1'b0;
      rfRd_q        <= '0;
      rfWdata_q     <= '0;
      retireCount_q <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      off_q         <= off_d;
      rd_q          <= rd_d;
      rfWe_q        <= rfWe_d;
      rfRd_q        <= rfRd_d;
      rfWdata_q     <= rfWdata_d;
      retireCount_q <= retireCount_d;
    end
  end

  assign rf_we        = rfWe_q;
  assign rf_rd        = rfRd_q;
  assign rf_wdata     = rfWdata_q;
  assign retire_count = retireCount_q;

endmodule

// File: tb/tb_wb_retire.sv
// Directed bench for wb_retire (XLEN=32, CNT_W=4): a vector table for every
// result select plus hand-written sequences for waits, flushes, wrap and reset.
module tb_wb_retire;

  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int CNT_W = 4;
  localparam int NVEC  = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_sel;
  logic [XLEN-1:0]   in_alu, in_uimm, in_pc;
  logic              in_br_en;
  logic [RD_W-1:0]   in_rd;
  logic [1:0]        in_off;
  logic              flush;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              rf_we;
  logic [RD_W-1:0]   rf_rd;
  logic [XLEN-1:0]   rf_wdata;
  logic [CNT_W-1:0]  retire_count;

  wb_retire #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_alu(in_alu), .in_uimm(in_uimm), .in_pc(in_pc), .in_br_en(in_br_en),
    .in_rd(in_rd), .in_off(in_off), .flush(flush),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  off;
    logic [31:0] alu;
    logic [31:0] uimm;
    logic [31:0] pc;
    logic        brEn;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        expWe;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [NVEC];
  int   checks = 0;
  int   fails  = 0;
  int   expCount = 0;
  logic [4:0]  lastRd = '0;
  logic [31:0] lastData = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] sel, input logic [1:0] off,
                               input logic [31:0] alu, input logic [31:0] uimm,
                               input logic [31:0] pc, input logic brEn, input logic [4:0] rd);
    in_valid = valid;
    in_sel   = sel;
    in_off   = off;
    in_alu   = alu;
    in_uimm  = uimm;
    in_pc    = pc;
    in_br_en = brEn;
    in_rd    = rd;
  endtask

  function automatic logic isLoadSel(input logic [3:0] sel);
    return (sel >= 4'd3 && sel <= 4'd7) || sel == 4'd9 || sel == 4'd10;
  endfunction

  task automatic expectRetire(input logic we, input logic [4:0] rd, input logic [31:0] data);
    expCount = (expCount + 1) % 16;
    if (we) begin
      lastRd   = rd;
      lastData = data;
    end
  endtask

  task automatic checkWritePort(input string tag, input logic we);
    checkOutput({tag, "_we"}, rf_we, we);
    checkOutput({tag, "_rd"}, rf_rd, lastRd);
    checkOutput({tag, "_wdata"}, rf_wdata, lastData);
    checkOutput({tag, "_count"}, retire_count, expCount);
  endtask

  initial begin
    //                sel    off  alu           uimm          pc            br  rd     rdata         we    expData
    vecs[0]  = '{4'd0,  2'd0, 32'h0000_1234, 32'h0,        32'h0,        1'b0, 5'd3,  32'h0,        1'b1, 32'h0000_1234};
    vecs[1]  = '{4'd1,  2'd0, 32'hFFFF_FFFF, 32'h0,        32'h0,        1'b1, 5'd4,  32'h0,        1'b1, 32'h0000_0001};
    vecs[2]  = '{4'd2,  2'd0, 32'h1,         32'hABCD_0000, 32'h0,       1'b0, 5'd6,  32'h0,        1'b1, 32'hABCD_0000};
    vecs[3]  = '{4'd8,  2'd0, 32'h1,         32'h0,        32'h0000_1000, 1'b0, 5'd7, 32'h0,        1'b1, 32'h0000_1004};
    vecs[4]  = '{4'd15, 2'd0, 32'h0000_0055, 32'h9,        32'h9,        1'b1, 5'd8,  32'h0,        1'b1, 32'h0000_0055};
    vecs[5]  = '{4'd3,  2'd0, 32'h0,         32'h0,        32'h0,        1'b0, 5'd9,  32'h8000_1234, 1'b1, 32'h8000_1234};
    vecs[6]  = '{4'd4,  2'd2, 32'h0,         32'h0,        32'h0,        1'b0, 5'd10, 32'h8001_0000, 1'b1, 32'hFFFF_8001};
    vecs[7]  = '{4'd5,  2'd2, 32'h0,         32'h0,        32'h0,        1'b0, 5'd11, 32'h8001_0000, 1'b1, 32'h0000_8001};
    vecs[8]  = '{4'd6,  2'd2, 32'h0,         32'h0,        32'h0,        1'b0, 5'd12, 32'h0080_0000, 1'b1, 32'hFFFF_FF80};
    vecs[9]  = '{4'd7,  2'd3, 32'h0,         32'h0,        32'h0,        1'b0, 5'd13, 32'h9A00_0000, 1'b1, 32'h0000_009A};
    vecs[10] = '{4'd4,  2'd3, 32'h0,         32'h0,        32'h0,        1'b0, 5'd14, 32'h1234_5678, 1'b1, 32'h0000_7812};
    vecs[11] = '{4'd3,  2'd1, 32'h0,         32'h0,        32'h0,        1'b0, 5'd15, 32'h1234_5678, 1'b1, 32'h7812_3456};
    vecs[12] = '{4'd9,  2'd0, 32'h0,         32'h0,        32'h0,        1'b0, 5'd16, 32'hFEDC_BA98, 1'b1, 32'hFEDC_BA98};
    vecs[13] = '{4'd10, 2'd2, 32'h0,         32'h0,        32'h0,        1'b0, 5'd17, 32'h1122_3344, 1'b1, 32'h3344_1122};
    vecs[14] = '{4'd8,  2'd0, 32'h0,         32'h0,        32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
    vecs[15] = '{4'd8,  2'd0, 32'h0,         32'h0,        32'hFFFF_FFFC, 1'b0, 5'd5, 32'h0,        1'b1, 32'h0000_0000};
    vecs[16] = '{4'd6,  2'd1, 32'h0,         32'h0,        32'h0,        1'b0, 5'd0,  32'h0000_7F00, 1'b0, 32'h0};

    rst = 1'b0;
    flush = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b1, 4'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1);

    // Reset state; in_ready must stay low while rst=0 even with a valid pending.
    step();
    step();
    checkOutput("rst_ready", in_ready, 1'b0);
    checkWritePort("rst", 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("idle_ready", in_ready, 1'b1);

    // Vector table: one instruction at a time, loads answered the cycle after acceptance.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b1, vecs[i].sel, vecs[i].off, vecs[i].alu, vecs[i].uimm,
                    vecs[i].pc, vecs[i].brEn, vecs[i].rd);
      step();
      in_valid = 1'b0;
      if (isLoadSel(vecs[i].sel)) begin
        #1;
        checkOutput($sformatf("v%0d_wait_ready", i), in_ready, 1'b0);
        checkOutput($sformatf("v%0d_wait_we", i), rf_we, 1'b0);
        mem_resp_valid = 1'b1;
        mem_rdata = vecs[i].rdata;
        step();
        mem_resp_valid = 1'b0;
      end
      expectRetire(vecs[i].expWe, vecs[i].rd, vecs[i].expData);
      checkWritePort($sformatf("v%0d", i), vecs[i].expWe);
      step();
      checkOutput($sformatf("v%0d_idle_we", i), rf_we, 1'b0);
    end

    // lb off=2, response three cycles after acceptance.
    applyStimulus(1'b1, 4'd6, 2'd2, 32'h0, 32'h0, 32'h0, 1'b0, 5'd12);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput("lbwait_ready", in_ready, 1'b0);
      checkOutput("lbwait_we", rf_we, 1'b0);
      step();
    end
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0080_0000;
    step();
    mem_resp_valid = 1'b0;
    expectRetire(1'b1, 5'd12, 32'hFFFF_FF80);
    checkWritePort("lb3", 1'b1);
    step();

    // A response coincident with load acceptance is ignored.
    applyStimulus(1'b1, 4'd3, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd20);
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    mem_resp_valid = 1'b0;
    checkOutput("early_we", rf_we, 1'b0);
    checkOutput("early_ready", in_ready, 1'b0);
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0000_0042;
    step();
    mem_resp_valid = 1'b0;
    expectRetire(1'b1, 5'd20, 32'h0000_0042);
    checkWritePort("early", 1'b1);
    step();

    // Five back-to-back alu ops.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4'd0, 2'd0, 32'h100 + k, 32'h0, 32'h0, 1'b0, 5'(k + 1));
      step();
      expectRetire(1'b1, 5'(k + 1), 32'h100 + k);
      checkWritePort($sformatf("b2b%0d", k), 1'b1);
    end
    in_valid = 1'b0;
    step();
    checkOutput("b2b_end_we", rf_we, 1'b0);

    // lhu flushed while waiting, response arrives in DRAIN and is dropped.
    applyStimulus(1'b1, 4'd5, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd21);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checkOutput("drain_ready", in_ready, 1'b0);
    checkOutput("drain_we", rf_we, 1'b0);
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0000_BEEF;
    step();
    mem_resp_valid = 1'b0;
    checkOutput("drained_ready", in_ready, 1'b1);
    checkWritePort("drained", 1'b0);

    // Flush and response together in WAIT_MEM go straight back to IDLE.
    applyStimulus(1'b1, 4'd3, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd19);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    flush = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    checkOutput("flushresp_ready", in_ready, 1'b1);
    checkWritePort("flushresp", 1'b0);

    // Flush during WRITE keeps the write but blocks the next acceptance.
    applyStimulus(1'b1, 4'd0, 2'd0, 32'h77, 32'h0, 32'h0, 1'b0, 5'd22);
    step();
    expectRetire(1'b1, 5'd22, 32'h77);
    checkWritePort("wrflush", 1'b1);
    applyStimulus(1'b1, 4'd0, 2'd0, 32'h88, 32'h0, 32'h0, 1'b0, 5'd23);
    flush = 1'b1;
    #1;
    checkOutput("wrflush_ready", in_ready, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkWritePort("wrflush_after", 1'b0);

    // Bring the counter to 15, then one more retirement wraps it to 0.
    begin
      int need;
      need = 15 - expCount;
      for (int k = 0; k < need; k++) begin
        applyStimulus(1'b1, 4'd0, 2'd0, 32'h200 + k, 32'h0, 32'h0, 1'b0, 5'd2);
        step();
        expectRetire(1'b1, 5'd2, 32'h200 + k);
      end
    end
    in_valid = 1'b0;
    step();
    checkOutput("count_max", retire_count, 4'd15);
    applyStimulus(1'b1, 4'd0, 2'd0, 32'h300, 32'h0, 32'h0, 1'b0, 5'd2);
    step();
    in_valid = 1'b0;
    checkOutput("count_wrap", retire_count, 4'd0);
    checkOutput("count_wrap_wdata", rf_wdata, 32'h300);
    step();

    // Reset in WAIT_MEM abandons the load; a later response in IDLE does nothing.
    applyStimulus(1'b1, 4'd3, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd24);
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready", in_ready, 1'b0);
    step();
    rst = 1'b1;
    checkOutput("midrst_we", rf_we, 1'b0);
    checkOutput("midrst_rd", rf_rd, 5'd0);
    checkOutput("midrst_wdata", rf_wdata, 32'h0);
    checkOutput("midrst_count", retire_count, 4'd0);
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0000_FFFF;
    step();
    mem_resp_valid = 1'b0;
    checkOutput("postrst_we", rf_we, 1'b0);
    checkOutput("postrst_wdata", rf_wdata, 32'h0);
    checkOutput("postrst_count", retire_count, 4'd0);
    checkOutput("postrst_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_retire.md
WB_RETIRE -- requirements
Module: wb_retire

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter RD_W, default 5, destination register index width.
REQ-003 Parameter CNT_W, default 32, retire counter width.
REQ-004 Derived OFF_W = log2(XLEN/8), the load byte-offset width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-007 in_valid  in  1  upstream instruction valid.
REQ-008 in_ready  out  1  block accepts upstream instruction this cycle.
REQ-009 in_sel  in  4  result select: 0 alu, 1 br_en, 2 u_imm, 3 lw, 4 lh, 5 lhu, 6 lb, 7 lbu, 8 pc_plus4, 9 ld, 10 lwu; other codes are treated as 0.
REQ-010 in_alu, in_uimm, in_pc  in  XLEN each  result candidates.
REQ-011 in_br_en  in  1  branch compare result.
REQ-012 in_rd  in  RD_W  destination register.
REQ-013 in_off  in  OFF_W  low address bits of a load.
REQ-014 flush  in  1  kill an uncommitted instruction.
REQ-015 mem_resp_valid  in  1  load data valid; mem_rdata  in  XLEN  aligned word/doubleword.
REQ-016 rf_we  out  1; rf_rd  out  RD_W; rf_wdata  out  XLEN  register-file write port.
REQ-017 retire_count  out  CNT_W  instructions retired since reset.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_MEM, WRITE and DRAIN.
REQ-019 in_ready SHALL be 1 in IDLE and WRITE when flush=0, and 0 otherwise.
REQ-020 Acceptance SHALL occur when in_valid and in_ready are both 1; accepted fields are latched in one internal entry.
REQ-021 A non-load accepted in cycle N SHALL go to WRITE, with rf_we=1 in cycle N+1 (latency 1, throughput 1/cycle).
REQ-022 A load (sel 3-7, 9, 10) SHALL go to WAIT_MEM; the cycle after mem_resp_valid=1 the block SHALL be in WRITE with the extracted data.
REQ-023 If mem_resp_valid=1 in the same cycle as load acceptance, the response SHALL be ignored; responses are only consumed in WAIT_MEM or DRAIN.
REQ-024 Extraction SHALL select the byte/half/word at byte offset in_off*1 within mem_rdata: lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend to XLEN; ld passes through.
REQ-025 Misaligned offsets (half at odd offset, word at offset not a multiple of 4) SHALL wrap within the XLEN word using modulo byte indexing and SHALL NOT raise any error.
REQ-026 ld and lwu with XLEN=32 SHALL behave as lw.
REQ-027 br_en SHALL produce zero-extended in_br_en; pc_plus4 SHALL produce in_pc+4 modulo 2^XLEN.
REQ-028 In WRITE: rf_we=1 when rd!=0; rf_we=0 when rd=0; the instruction retires either way.
REQ-029 From WRITE the FSM SHALL go to WAIT_MEM/WRITE on a new acceptance, otherwise to IDLE.
REQ-030 flush in WAIT_MEM SHALL move to DRAIN, or to IDLE if mem_resp_valid=1 that cycle; DRAIN SHALL wait for one mem_resp_valid, discard it, and then return to IDLE.
REQ-031 flush in WRITE SHALL NOT cancel that write; it blocks acceptance for that cycle.
REQ-032 Flushed instructions SHALL NOT increment retire_count.
REQ-033 retire_count SHALL increment by 1 per WRITE cycle and wrap to 0 after 2^CNT_W-1.
REQ-034 rf_rd and rf_wdata SHALL hold their last value when rf_we=0.

Reset
REQ-035 While rst=0 at a clock edge: FSM=IDLE, rf_we=0, rf_rd=0, rf_wdata=0, retire_count=0, and the entry is invalidated.
REQ-036 Reset in WAIT_MEM or DRAIN SHALL abandon the pending load; later responses in IDLE are ignored.
REQ-037 in_ready SHALL be 0 during the cycle in which rst=0.

Verification
REQ-038 XLEN=32: alu op, alu=0x1234, rd=3, accepted at cycle 10 -> rf_we=1, rf_rd=3, rf_wdata=0x1234 at cycle 11, retire_count=1.
REQ-039 lb, off=2, mem_rdata=0x00800000, response 3 cycles after accept -> rf_wdata=0xFFFFFF80 one cycle after the response; in_ready=0 while waiting.
REQ-040 Back-to-back: five alu ops in consecutive cycles -> five consecutive rf_we pulses, retire_count=5.
REQ-041 lhu issued, flush 1 cycle later, response 2 cycles later -> no rf_we, FSM returns to IDLE, retire_count unchanged.
REQ-042 rd=0 pc_plus4 with pc=0xFFFFFFFC -> rf_we=0, retire_count+1; rd=5 -> rf_wdata=0x00000000.
REQ-043 retire_count preset by 2^CNT_W-1 retirements (CNT_W=4: 15), one more retire -> 0; rst=0 mid-WAIT_MEM -> all outputs 0 next cycle.
